cpu_datapath: RTL and testbench

// 32-bit single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z, ALU, in/out ports.

---
 rtl/cpu_datapath_if.sv | 44 ++++
 rtl/cpu_datapath.sv | 141 ++++++++++++++
 tb/tb_cpu_datapath.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Strobe, data and observation signals between the control unit (master) and
// the single-bus CPU datapath (slave).
interface cpu_datapath_if;
  logic [4:0]  opcode;
  logic [15:0] enable;
  logic [15:0] Rout;
  logic        PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout;
  logic        PC_enable, MAR_enable, MDRin, IR_enable, Yin, HIin, LOin;
  logic        ZHigh_enable, ZLow_enable, OutPort_enable;
  logic        mdr_read;
  logic [31:0] Mdatain;
  logic [31:0] InPort_data_in;
  logic [31:0] RY_immediate;

  logic [31:0] bus_data;
  logic [31:0] OutPort_data_out;
  logic [31:0] mar_addr;
  // IR contents, needed by the control unit's decoder
  logic [31:0] ir_data;
  logic [31:0] r3_debug, r4_debug, r7_debug, pc_debug, ZHigh_debug, ZLow_debug;
  logic        r3in, r4in, r7in;

  modport master (
    output opcode, enable, Rout,
    output PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout,
    output PC_enable, MAR_enable, MDRin, IR_enable, Yin, HIin, LOin,
    output ZHigh_enable, ZLow_enable, OutPort_enable,
    output mdr_read, Mdatain, InPort_data_in, RY_immediate,
    input  bus_data, OutPort_data_out, mar_addr, ir_data,
    input  r3_debug, r4_debug, r7_debug, pc_debug, ZHigh_debug, ZLow_debug,
    input  r3in, r4in, r7in
  );

  modport slave (
    input  opcode, enable, Rout,
    input  PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout,
    input  PC_enable, MAR_enable, MDRin, IR_enable, Yin, HIin, LOin,
    input  ZHigh_enable, ZLow_enable, OutPort_enable,
    input  mdr_read, Mdatain, InPort_data_in, RY_immediate,
    output bus_data, OutPort_data_out, mar_addr, ir_data,
    output r3_debug, r4_debug, r7_debug, pc_debug, ZHigh_debug, ZLow_debug,
    output r3in, r4in, r7in
  );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z, ALU.
// Define DATAPATH_DEBUG_EN to route live R3/R4/R7/PC/Z onto the *_debug taps.
module cpu_datapath (
  input  logic          clk,
  input  logic          clear,
  cpu_datapath_if.slave dp
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [31:0] r_gpr [16];
  logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_hi, r_lo, r_y, r_zhi, r_zlo, r_outport;

  logic [31:0]        w_bus;
  logic [63:0]        w_alu;
  logic [4:0]         w_sh;
  logic [63:0]        w_rotr, w_rotl;
  logic signed [31:0] w_shra;
  logic signed [63:0] w_a64, w_b64, w_prod;
  logic signed [31:0] w_div_b, w_quo, w_rem;

  // Fixed-priority bus mux: later assignments override, so Rout[0] wins overall.
  always_comb begin
    // NOTE: default first so every path assigns w_bus and no latch is inferred.
    w_bus = '0;
    if (dp.Cout)      w_bus = dp.RY_immediate;
    if (dp.InPortout) w_bus = dp.InPort_data_in;
    if (dp.MDRout)    w_bus = r_mdr;
    if (dp.LOout)     w_bus = r_lo;
    if (dp.HIout)     w_bus = r_hi;
    if (dp.ZLowout)   w_bus = r_zlo;
    if (dp.ZHighout)  w_bus = r_zhi;
    if (dp.PCout)     w_bus = r_pc;
    for (int i = 15; i >= 0; i--) begin
      if (dp.Rout[i]) w_bus = r_gpr[i];
    end
  end

  assign w_sh    = w_bus[4:0];
  assign w_rotr  = {r_y, r_y} >> w_sh;
  assign w_rotl  = {r_y, r_y} << w_sh;
  assign w_shra  = $signed(r_y) >>> w_sh;
  assign w_a64   = {{32{r_y[31]}}, r_y};
  assign w_b64   = {{32{w_bus[31]}}, w_bus};
  assign w_prod  = w_a64 * w_b64;
  // Divisor forced nonzero so the divider never sees 0; the B=0 result is selected below.
  assign w_div_b = (w_bus == '0) ? 32'sd1 : $signed(w_bus);
  assign w_quo   = $signed(r_y) / w_div_b;
  assign w_rem   = $signed(r_y) % w_div_b;

  always_comb begin
    w_alu = {32'd0, w_bus};
    case (dp.opcode)
      OP_ADD:  w_alu = {32'd0, r_y + w_bus};
      OP_SUB:  w_alu = {32'd0, r_y - w_bus};
      OP_AND:  w_alu = {32'd0, r_y & w_bus};
      OP_OR:   w_alu = {32'd0, r_y | w_bus};
      OP_ROR:  w_alu = {32'd0, w_rotr[31:0]};
      OP_ROL:  w_alu = {32'd0, w_rotl[63:32]};
      OP_SHR:  w_alu = {32'd0, r_y >> w_sh};
      OP_SHRA: w_alu = {32'd0, w_shra};
      OP_SHL:  w_alu = {32'd0, r_y << w_sh};
      OP_MUL:  w_alu = w_prod;
      OP_DIV:  w_alu = (w_bus == '0) ? {r_y, 32'd0} : {w_rem, w_quo};
      OP_NEG:  w_alu = {32'd0, -w_bus};
      OP_NOT:  w_alu = {32'd0, ~w_bus};
      default: w_alu = {32'd0, w_bus};
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: the register file is 16 discrete flops, so it clears with everything else.
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc      <= '0;
      r_ir      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_y       <= '0;
      r_zhi     <= '0;
      r_zlo     <= '0;
      r_outport <= '0;
    end else begin
      // NOTE: non-blocking, so a register driven and loaded in one cycle reads its old value.
      for (int i = 0; i < 16; i++) begin
        if (dp.enable[i]) r_gpr[i] <= w_bus;
      end
      if (dp.PC_enable)      r_pc      <= w_bus;
      if (dp.IR_enable)      r_ir      <= w_bus;
      if (dp.MAR_enable)     r_mar     <= w_bus;
      if (dp.MDRin)          r_mdr     <= dp.mdr_read ? dp.Mdatain : w_bus;
      if (dp.HIin)           r_hi      <= w_bus;
      if (dp.LOin)           r_lo      <= w_bus;
      if (dp.Yin)            r_y       <= w_bus;
      if (dp.ZHigh_enable)   r_zhi     <= w_alu[63:32];
      if (dp.ZLow_enable)    r_zlo     <= w_alu[31:0];
      if (dp.OutPort_enable) r_outport <= w_bus;
    end
  end

  assign dp.bus_data         = w_bus;
  assign dp.OutPort_data_out = r_outport;
  assign dp.mar_addr         = r_mar;
  assign dp.ir_data          = r_ir;
  assign dp.r3in             = dp.enable[3];
  assign dp.r4in             = dp.enable[4];
  assign dp.r7in             = dp.enable[7];

`ifdef DATAPATH_DEBUG_EN
  assign dp.r3_debug    = r_gpr[3];
  assign dp.r4_debug    = r_gpr[4];
  assign dp.r7_debug    = r_gpr[7];
  assign dp.pc_debug    = r_pc;
  assign dp.ZHigh_debug = r_zhi;
  assign dp.ZLow_debug  = r_zlo;
`else
  assign dp.r3_debug    = '0;
  assign dp.r4_debug    = '0;
  assign dp.r7_debug    = '0;
  assign dp.pc_debug    = '0;
  assign dp.ZHigh_debug = '0;
  assign dp.ZLow_debug  = '0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized
// strobes checked against an architectural model of the register set and ALU.
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  cpu_datapath_if dp ();
  cpu_datapath u_dut (.clk(clk), .clear(clear), .dp(dp));

  logic [31:0] m_gpr [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_out;
  logic [63:0] m_z;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 16; i++) if (dp.Rout[i]) return m_gpr[i];
    if (dp.PCout)     return m_pc;
    if (dp.ZHighout)  return m_z[63:32];
    if (dp.ZLowout)   return m_z[31:0];
    if (dp.HIout)     return m_hi;
    if (dp.LOout)     return m_lo;
    if (dp.MDRout)    return m_mdr;
    if (dp.InPortout) return dp.InPort_data_in;
    if (dp.Cout)      return dp.RY_immediate;
    return 32'd0;
  endfunction

  function automatic logic [63:0] model_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    int unsigned s;
    longint p;
    sa = a;
    sb = b;
    s  = b % 32;
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a & b};
      5'd6:  return {32'd0, a | b};
      5'd7:  return {32'd0, (s == 0) ? a : ((a >> s) | (a << (32 - s)))};
      5'd8:  return {32'd0, (s == 0) ? a : ((a << s) | (a >> (32 - s)))};
      5'd9:  return {32'd0, a >> s};
      5'd10: return {32'd0, 32'(sa >>> s)};
      5'd11: return {32'd0, a << s};
      5'd15: begin p = longint'(sa) * longint'(sb); return p; end
      5'd16: begin
        if (b == 32'd0) return {a, 32'd0};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  task automatic idle();
    clear = 1'b0;
    dp.opcode = '0; dp.enable = '0; dp.Rout = '0;
    dp.PCout = 0; dp.ZHighout = 0; dp.ZLowout = 0; dp.HIout = 0;
    dp.LOout = 0; dp.MDRout = 0; dp.InPortout = 0; dp.Cout = 0;
    dp.PC_enable = 0; dp.MAR_enable = 0; dp.MDRin = 0; dp.IR_enable = 0;
    dp.Yin = 0; dp.HIin = 0; dp.LOin = 0; dp.ZHigh_enable = 0;
    dp.ZLow_enable = 0; dp.OutPort_enable = 0; dp.mdr_read = 0;
    dp.Mdatain = '0; dp.InPort_data_in = '0; dp.RY_immediate = '0;
  endtask

  // One clock edge: the model takes the architectural effect of the strobes held now.
  task automatic tick();
    logic [31:0] b;
    logic [63:0] r;
    b = model_bus();
    r = model_alu(dp.opcode, m_y, b);
    @(posedge clk);
    if (clear) begin
      for (int i = 0; i < 16; i++) m_gpr[i] = '0;
      {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_out} = '0;
      m_z = '0;
    end else begin
      for (int i = 0; i < 16; i++) if (dp.enable[i]) m_gpr[i] = b;
      if (dp.PC_enable)      m_pc  = b;
      if (dp.IR_enable)      m_ir  = b;
      if (dp.MAR_enable)     m_mar = b;
      if (dp.MDRin)          m_mdr = dp.mdr_read ? dp.Mdatain : b;
      if (dp.HIin)           m_hi  = b;
      if (dp.LOin)           m_lo  = b;
      if (dp.Yin)            m_y   = b;
      if (dp.ZHigh_enable)   m_z[63:32] = r[63:32];
      if (dp.ZLow_enable)    m_z[31:0]  = r[31:0];
      if (dp.OutPort_enable) m_out = b;
    end
    @(negedge clk);
  endtask

  // Observe a register through the bus: 0-15 GPR, 16 PC, 17 ZHigh, 18 ZLow, 19 HI, 20 LO, 21 MDR.
  task automatic peek(input int sel, output logic [31:0] v);
    dp.Rout = '0;
    {dp.PCout, dp.ZHighout, dp.ZLowout, dp.HIout, dp.LOout, dp.MDRout, dp.InPortout, dp.Cout} = '0;
    if (sel < 16) dp.Rout[sel] = 1'b1;
    else case (sel)
      16: dp.PCout = 1'b1;
      17: dp.ZHighout = 1'b1;
      18: dp.ZLowout = 1'b1;
      19: dp.HIout = 1'b1;
      20: dp.LOout = 1'b1;
      default: dp.MDRout = 1'b1;
    endcase
    #1;
    v = dp.bus_data;
    dp.Rout = '0;
    {dp.PCout, dp.ZHighout, dp.ZLowout, dp.HIout, dp.LOout, dp.MDRout} = '0;
  endtask

  function automatic logic [31:0] model_src(int sel);
    if (sel < 16) return m_gpr[sel];
    case (sel)
      16: return m_pc;
      17: return m_z[63:32];
      18: return m_z[31:0];
      19: return m_hi;
      20: return m_lo;
      default: return m_mdr;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] taps [9];
    logic [31:0] x;
    idle();
    for (int k = 0; k < 8; k++) begin
      dp.Cout = 1; dp.RY_immediate = $urandom | 32'h1; dp.enable = 16'hFFFF;
      {dp.PC_enable, dp.MAR_enable, dp.MDRin, dp.IR_enable, dp.Yin, dp.HIin, dp.LOin} = '1;
      {dp.ZHigh_enable, dp.ZLow_enable, dp.OutPort_enable} = '1;
      dp.opcode = 5'($urandom_range(0, 31));
      tick();
    end
    clear = 1'b1;
    tick();
    idle();
    for (int s = 0; s < 22; s++) begin
      peek(s, v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++; $display("FAIL reset_src%0d got=%h want=00000000", s, v);
      end
    end
    #1;
    taps = '{dp.mar_addr, dp.OutPort_data_out, dp.ir_data, dp.r3_debug, dp.r4_debug,
             dp.r7_debug, dp.pc_debug, dp.ZHigh_debug, dp.ZLow_debug};
    for (int t = 0; t < 9; t++) begin
      n_vec++;
      if (taps[t] !== 32'd0) begin
        n_err++; $display("FAIL reset_tap%0d got=%h want=00000000", t, taps[t]);
      end
    end
    // Y cleared: Z = Y + x must equal x
    x = $urandom;
    dp.Cout = 1; dp.RY_immediate = x; dp.opcode = 5'd3; dp.ZLow_enable = 1;
    tick(); idle();
    peek(18, v);
    n_vec++;
    if (v !== x) begin n_err++; $display("FAIL reset_y got=%h want=%h", v, x); end
  endtask

  task automatic test_load_imm();
    logic [31:0] v;
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'd5; dp.enable = 16'h0004; tick();
    dp.RY_immediate = 32'd3; dp.enable = 16'h0040; tick();
    idle();
    peek(2, v); n_vec++;
    if (v !== 32'd5) begin n_err++; $display("FAIL load_r2 got=%h want=5", v); end
    peek(6, v); n_vec++;
    if (v !== 32'd3) begin n_err++; $display("FAIL load_r6 got=%h want=3", v); end
  endtask

  task automatic test_sub();
    logic [31:0] v;
    idle();
    dp.Rout = 16'h0004; dp.Yin = 1; tick();
    idle();
    dp.Rout = 16'h0040; dp.opcode = 5'b00100; dp.ZLow_enable = 1; dp.ZHigh_enable = 1; tick();
    idle();
    dp.ZLowout = 1; dp.enable = 16'h0008; #1;
    n_vec++;
    if ({dp.r3in, dp.r4in, dp.r7in} !== 3'b100) begin
      n_err++; $display("FAIL sub_rin got=%b want=100", {dp.r3in, dp.r4in, dp.r7in});
    end
    tick(); idle();
    peek(3, v); n_vec++;
    if (v !== 32'd2) begin n_err++; $display("FAIL sub_r3 got=%h want=2", v); end
    peek(17, v); n_vec++;
    if (v !== 32'd0) begin n_err++; $display("FAIL sub_zhigh got=%h want=0", v); end
  endtask

  task automatic test_mdr();
    idle();
    dp.mdr_read = 1; dp.Mdatain = 32'h2A2B8000; dp.MDRin = 1;
    dp.Cout = 1; dp.RY_immediate = 32'h12345678;
    tick(); idle();
    dp.MDRout = 1; dp.IR_enable = 1; #1;
    n_vec++;
    if (dp.bus_data !== 32'h2A2B8000) begin
      n_err++; $display("FAIL mdr_bus got=%h want=2a2b8000", dp.bus_data);
    end
    tick(); idle(); #1;
    n_vec++;
    if (dp.ir_data !== 32'h2A2B8000) begin
      n_err++; $display("FAIL mdr_ir got=%h want=2a2b8000", dp.ir_data);
    end
  endtask

  task automatic test_mul_div();
    logic [31:0] hi, lo;
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'hFFFFFFFE; dp.Yin = 1; tick();
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'd3; dp.opcode = 5'b01111;
    dp.ZLow_enable = 1; dp.ZHigh_enable = 1; tick();
    idle(); peek(17, hi); peek(18, lo);
    n_vec++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_err++; $display("FAIL mul got=%h%h want=fffffffffffffffa", hi, lo);
    end
    dp.Cout = 1; dp.RY_immediate = 32'd0; dp.opcode = 5'b10000;
    dp.ZLow_enable = 1; dp.ZHigh_enable = 1; tick();
    idle(); peek(17, hi); peek(18, lo);
    n_vec++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000000) begin
      n_err++; $display("FAIL div0 got=%h%h want=fffffffe00000000", hi, lo);
    end
  endtask

  task automatic test_priority();
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'h11111111; dp.enable = 16'h0002; tick();
    dp.RY_immediate = 32'h22222222; dp.enable = 16'h0000; dp.PC_enable = 1; tick();
    idle();
    dp.PCout = 1; dp.Rout = 16'h0002; #1;
    n_vec++;
    if (dp.bus_data !== 32'h11111111) begin
      n_err++; $display("FAIL prio_r1 got=%h want=11111111", dp.bus_data);
    end
    dp.Rout = '0; #1;
    n_vec++;
    if (dp.bus_data !== 32'h22222222) begin
      n_err++; $display("FAIL prio_pc got=%h want=22222222", dp.bus_data);
    end
    idle(); #1;
    n_vec++;
    if (dp.bus_data !== 32'd0) begin
      n_err++; $display("FAIL prio_none got=%h want=0", dp.bus_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'd1; dp.Yin = 1; tick();
    idle();
    dp.Cout = 1; dp.RY_immediate = 32'd10; dp.ZLow_enable = 1; tick();
    idle();
    dp.ZLowout = 1; dp.opcode = 5'd3; dp.ZLow_enable = 1; tick(); tick();
    idle(); peek(18, v);
    n_vec++;
    if (v !== 32'd12) begin n_err++; $display("FAIL b2b_zlow got=%h want=c", v); end
  endtask

  task automatic test_random();
    logic [4:0]   ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                               5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
    logic [191:0] dbg_exp;
    logic [31:0]  v;
    for (int k = 0; k < 400; k++) begin
      idle();
      case ($urandom_range(0, 3))
        1: dp.Rout[$urandom_range(0, 15)] = 1'b1;
        2: dp.Rout = 16'($urandom);
        default: dp.Rout = '0;
      endcase
      {dp.PCout, dp.ZHighout, dp.ZLowout, dp.HIout} =
        {$urandom_range(0,7) == 0, $urandom_range(0,7) == 0, $urandom_range(0,7) == 0, $urandom_range(0,7) == 0};
      {dp.LOout, dp.MDRout, dp.InPortout, dp.Cout} =
        {$urandom_range(0,7) == 0, $urandom_range(0,7) == 0, $urandom_range(0,7) == 0, $urandom_range(0,1) == 0};
      dp.enable = 16'($urandom & $urandom);
      {dp.PC_enable, dp.MAR_enable, dp.MDRin, dp.IR_enable, dp.Yin} = 5'($urandom & $urandom);
      {dp.HIin, dp.LOin, dp.ZHigh_enable, dp.ZLow_enable, dp.OutPort_enable} = 5'($urandom);
      dp.mdr_read = 1'($urandom);
      dp.Mdatain = $urandom; dp.InPort_data_in = $urandom;
      dp.RY_immediate = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      dp.opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
      if (dp.opcode == 5'd16 && m_y == 32'h80000000 && model_bus() == 32'hFFFFFFFF) dp.opcode = 5'd3;
      clear = ($urandom_range(0, 63) == 0);
      #1;
      n_vec++;
      if (dp.bus_data !== model_bus()) begin
        n_err++; $display("FAIL rnd_bus[%0d] got=%h want=%h", k, dp.bus_data, model_bus());
      end
      n_vec++;
      if ({dp.mar_addr, dp.OutPort_data_out, dp.ir_data} !== {m_mar, m_out, m_ir}) begin
        n_err++; $display("FAIL rnd_regs[%0d] got=%h want=%h", k,
                          {dp.mar_addr, dp.OutPort_data_out, dp.ir_data}, {m_mar, m_out, m_ir});
      end
      n_vec++;
      if ({dp.r3in, dp.r4in, dp.r7in} !== {dp.enable[3], dp.enable[4], dp.enable[7]}) begin
        n_err++; $display("FAIL rnd_rin[%0d] got=%b want=%b", k, {dp.r3in, dp.r4in, dp.r7in},
                          {dp.enable[3], dp.enable[4], dp.enable[7]});
      end
`ifdef DATAPATH_DEBUG_EN
      dbg_exp = {m_gpr[3], m_gpr[4], m_gpr[7], m_pc, m_z};
`else
      dbg_exp = '0;
`endif
      n_vec++;
      if ({dp.r3_debug, dp.r4_debug, dp.r7_debug, dp.pc_debug, dp.ZHigh_debug, dp.ZLow_debug} !== dbg_exp) begin
        n_err++; $display("FAIL rnd_debug[%0d] got=%h want=%h", k,
                          {dp.r3_debug, dp.r4_debug, dp.r7_debug, dp.pc_debug, dp.ZHigh_debug, dp.ZLow_debug}, dbg_exp);
      end
      tick();
    end
    idle();
    for (int s = 0; s < 22; s++) begin
      peek(s, v);
      n_vec++;
      if (v !== model_src(s)) begin
        n_err++; $display("FAIL rnd_final_src%0d got=%h want=%h", s, v, model_src(s));
      end
    end
  endtask

  initial begin
    idle();
    clear = 1'b1;
    tick();
    test_reset();
    test_load_imm();
    test_sub();
    test_mdr();
    test_mul_div();
    test_priority();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
